// File: rtl/cla_pipe_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cla_pipe_pkg;

  localparam int CLA_WIDTH_DEF = 32;
  localparam int CLA_GROUP_DEF = 8;

  // Encoding of the sub input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Pipeline depth: one carry-lookahead slice per stage.
  function automatic int cla_stages(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit generate/propagate carry-lookahead slice.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline stage owns the handshake.
module cla_group
  import cla_pipe_pkg::*;
#(
  parameter int GROUP = CLA_GROUP_DEF
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of products: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci.
  always_comb begin : lookahead
    logic acc;
    logic pp;
    acc  = 1'b0;
    pp   = 1'b1;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (g[j] & pp);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (ci & pp);
    end
  end

  assign s        = p ^ c[GROUP-1:0];
  assign co       = c[GROUP];
  assign c_msb_in = c[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined add/sub: one GROUP-bit lookahead slice per stage; optional zero/neg flags with CLA_PIPE_FLAGS_EN.
// Latency: STAGES = WIDTH/GROUP cycles from acceptance to out_valid; one beat per cycle sustained.
// Backpressure: whole pipeline freezes while out_valid && !out_ready; in_ready mirrors that advance condition.
module cla_pipe_adder
  import cla_pipe_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH_DEF,
  parameter int GROUP = CLA_GROUP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef CLA_PIPE_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);

  localparam int STAGES = cla_stages(WIDTH, GROUP);
  localparam logic [WIDTH-1:0] GMASK = WIDTH'({GROUP{1'b1}});

  if ((GROUP < 1) || ((WIDTH % GROUP) != 0)) begin : g_cfg_check
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  // Whole-pipeline advance; bubbles travel with the beats and collapse at the output.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is a + ~b + 1; cin only matters for addition.
  logic [WIDTH-1:0] op_b;
  logic             op_c;
  assign op_b = (sub == OP_SUB) ? ~b : b;
  assign op_c = (sub == OP_SUB) ? 1'b1 : cin;

  // Stage registers. Operands ride along unchanged so each stage can pick its own slice;
  // s_q accumulates finished low slices (the deskew stack) as a beat moves up the pipe.
  logic             vld_q [STAGES];
  logic             c_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             ovf_q;

  // Per-stage inputs and slice results.
  logic             vld_in [STAGES];
  logic             ci_in  [STAGES];
  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] s_in   [STAGES];
  logic [WIDTH-1:0] s_nxt  [STAGES];
  logic [GROUP-1:0] gs     [STAGES];
  logic             gco    [STAGES];
  logic             gcm    [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vld_in[k] = in_valid;
      assign ci_in[k]  = op_c;
      assign a_in[k]   = a;
      assign b_in[k]   = op_b;
      assign s_in[k]   = '0;
    end else begin : g_body
      assign vld_in[k] = vld_q[k-1];
      assign ci_in[k]  = c_q[k-1];
      assign a_in[k]   = a_q[k-1];
      assign b_in[k]   = b_q[k-1];
      assign s_in[k]   = s_q[k-1];
    end

    cla_group #(
      .GROUP(GROUP)
    ) u_group (
      .a       (a_in[k][k*GROUP +: GROUP]),
      .b       (b_in[k][k*GROUP +: GROUP]),
      .ci      (ci_in[k]),
      .s       (gs[k]),
      .co      (gco[k]),
      .c_msb_in(gcm[k])
    );

    // Drop this stage's slice sum into its position, keep the lower finished slices.
    assign s_nxt[k] = (s_in[k] & ~(GMASK << (k*GROUP))) | (WIDTH'(gs[k]) << (k*GROUP));
  end

  // Pipeline register update: clear on reset, freeze everything when not advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        c_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_in[k];
        c_q[k]   <= gco[k];
        a_q[k]   <= a_in[k];
        b_q[k]   <= b_in[k];
        s_q[k]   <= s_nxt[k];
      end
      ovf_q <= gco[STAGES-1] ^ gcm[STAGES-1];
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

`ifdef CLA_PIPE_FLAGS_EN
  logic zero_q;
  logic neg_q;

  // Result flags registered alongside the final slice so they share out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (advance) begin
      zero_q <= (s_nxt[STAGES-1] == '0);
      neg_q  <= s_nxt[STAGES-1][WIDTH-1];
    end
  end

  assign zero = zero_q;
  assign neg  = neg_q;
`endif

endmodule
